// File: rtl/fbcpu_mem_loader_if.sv
// CPU memory bus plus program-loader stream for fbcpu_mem_loader.
// The memory block connects to the slave modport; the CPU/loader side uses master.
interface fbcpu_mem_loader_if #(
    parameter int unsigned ADDRESS_WIDTH = 6,
    parameter int unsigned DATA_WIDTH    = 10
);
    logic [ADDRESS_WIDTH-1:0] mar;
    logic                     ram_wr;
    logic [DATA_WIDTH-1:0]    mdr_in;
    logic [DATA_WIDTH-1:0]    mdr_out;
    logic                     cpu_rst;
    logic                     ld_valid;
    logic [DATA_WIDTH-1:0]    ld_data;
    logic                     ld_last;
    logic                     ld_ready;
    logic [ADDRESS_WIDTH:0]   ld_count;
    logic [DATA_WIDTH-1:0]    io_out;

    modport master (
        output mar, ram_wr, mdr_in, ld_valid, ld_data, ld_last,
        input  mdr_out, cpu_rst, ld_ready, ld_count, io_out
    );

    modport slave (
        input  mar, ram_wr, mdr_in, ld_valid, ld_data, ld_last,
        output mdr_out, cpu_rst, ld_ready, ld_count, io_out
    );
endinterface

// File: rtl/fbcpu_mem_loader.sv
// FBCPU program memory: holds the CPU in reset while a program streams in, then serves it.
// Define FBCPU_MEM_IO_EN to map the top word address onto the io_out register.
module fbcpu_mem_loader #(
    parameter int unsigned ADDRESS_WIDTH = 6,
    parameter int unsigned DATA_WIDTH    = 10
) (
    input logic              clk,
    input logic              rst,
    fbcpu_mem_loader_if.slave bus
);
    localparam int unsigned              Depth    = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] TopAddr  = '1;
    localparam logic [ADDRESS_WIDTH:0]   CountOne = 1;

    typedef enum logic [0:0] {StLoad, StRun} state_e;

    state_e                   state_q;
    logic [ADDRESS_WIDTH:0]   count_q;
    logic [DATA_WIDTH-1:0]    mdr_q;
    logic [DATA_WIDTH-1:0]    mem [Depth];

    logic                     in_load;
    logic                     xfer;
    logic                     last_xfer;
    logic                     cpu_wr;
    logic                     io_hit;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [DATA_WIDTH-1:0]    rd_word;

    assign in_load   = (state_q == StLoad);
    assign xfer      = in_load && bus.ld_valid;
    // Filling the last address ends the load even without ld_last.
    assign last_xfer = xfer && (bus.ld_last || (count_q[ADDRESS_WIDTH-1:0] == TopAddr));
    assign cpu_wr    = !in_load && bus.ram_wr;

`ifdef FBCPU_MEM_IO_EN
    logic [DATA_WIDTH-1:0] io_q;

    assign io_hit  = (bus.mar == TopAddr);
    assign rd_word = io_hit ? io_q : mem[bus.mar];

    always_ff @(posedge clk) begin
        if (rst) begin
            io_q <= '0;
        end else if (cpu_wr && io_hit) begin
            io_q <= bus.mdr_in;
        end
    end

    assign bus.io_out = io_q;
`else
    assign io_hit     = 1'b0;
    assign rd_word    = mem[bus.mar];
    assign bus.io_out = '0;
`endif

    always_comb begin
        mem_we  = 1'b0;
        wr_addr = bus.mar;
        wr_data = bus.mdr_in;
        if (!rst) begin
            if (xfer) begin
                mem_we  = 1'b1;
                wr_addr = count_q[ADDRESS_WIDTH-1:0];
                wr_data = bus.ld_data;
            end else if (cpu_wr && !io_hit) begin
                mem_we = 1'b1;
            end
        end
    end

    // Contents are never cleared so a partial reload keeps the older words.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoad;
            count_q <= '0;
            mdr_q   <= '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    mdr_q <= '0;
                    if (xfer) begin
                        count_q <= count_q + CountOne;
                        if (last_xfer) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    mdr_q <= rd_word;
                end
            endcase
        end
    end

    assign bus.mdr_out  = mdr_q;
    assign bus.cpu_rst  = in_load;
    assign bus.ld_ready = in_load;
    assign bus.ld_count = count_q;
endmodule

// File: tb/tb_fbcpu_mem_loader.sv
// Directed self-checking bench for fbcpu_mem_loader (works with or without FBCPU_MEM_IO_EN).
module tb_fbcpu_mem_loader;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 10;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    fbcpu_mem_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fbcpu_mem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [DW-1:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        step;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        bus.ram_wr = 1'b0;
        bus.mar    = a;
        step;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        bus.mar = 6'd5; bus.ram_wr = 1'b1; bus.mdr_in = 10'h123;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
        do_reset;
        bus.ram_wr = 1'b0;
        total++; if (bus.ld_count !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.ld_count); end
        total++; if (bus.cpu_rst !== 1'b1) begin bad++; $display("FAIL reset_cpu_rst got=%b want=1", bus.cpu_rst); end
        total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ld_ready); end
        total++; if (bus.mdr_out !== 10'h000) begin bad++; $display("FAIL reset_mdr got=%h want=000", bus.mdr_out); end
        total++; if (bus.io_out !== 10'h000) begin bad++; $display("FAIL reset_io got=%h want=000", bus.io_out); end
    endtask

    task automatic test_basic_load;
        bus.mar = 6'd0;
        load_word(10'h005, 1'b0);
        total++; if (bus.ld_count !== 7'd1) begin bad++; $display("FAIL load1_count got=%0d want=1", bus.ld_count); end
        total++; if (bus.mdr_out !== 10'h000) begin bad++; $display("FAIL load_mdr_zero got=%h want=000", bus.mdr_out); end
        load_word(10'h0C5, 1'b0);
        total++; if (bus.cpu_rst !== 1'b1) begin bad++; $display("FAIL load2_cpu_rst got=%b want=1", bus.cpu_rst); end
        load_word(10'h200, 1'b1);
        total++; if (bus.ld_count !== 7'd3) begin bad++; $display("FAIL load3_count got=%0d want=3", bus.ld_count); end
        total++; if (bus.cpu_rst !== 1'b0) begin bad++; $display("FAIL load3_cpu_rst got=%b want=0", bus.cpu_rst); end
        total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL load3_ready got=%b want=0", bus.ld_ready); end
        rd(6'd0);
        total++; if (bus.mdr_out !== 10'h005) begin bad++; $display("FAIL load_rd0 got=%h want=005", bus.mdr_out); end
        rd(6'd1);
        total++; if (bus.mdr_out !== 10'h0C5) begin bad++; $display("FAIL load_rd1 got=%h want=0c5", bus.mdr_out); end
        rd(6'd2);
        total++; if (bus.mdr_out !== 10'h200) begin bad++; $display("FAIL load_rd2 got=%h want=200", bus.mdr_out); end
    endtask

    task automatic test_cpu_rw;
        bus.mar = 6'd10; bus.ram_wr = 1'b1; bus.mdr_in = 10'h111;
        step;
        bus.mdr_in = 10'h3FF;
        step;
        total++; if (bus.mdr_out !== 10'h111) begin bad++; $display("FAIL rw_old_word got=%h want=111", bus.mdr_out); end
        rd(6'd10);
        total++; if (bus.mdr_out !== 10'h3FF) begin bad++; $display("FAIL rw_new_word got=%h want=3ff", bus.mdr_out); end
        load_word(10'h2AA, 1'b0);
        total++; if (bus.ld_count !== 7'd3) begin bad++; $display("FAIL run_ignore_valid got=%0d want=3", bus.ld_count); end
    endtask

    task automatic test_full;
        do_reset;
        for (int i = 0; i < 64; i++) begin
            load_word(10'((i * 7 + 3) % 1024), 1'b0);
            if (i == 62) begin
                total++; if (bus.cpu_rst !== 1'b1 || bus.ld_count !== 7'd63) begin
                    bad++; $display("FAIL full_63 got cpu_rst=%b count=%0d want 1/63", bus.cpu_rst, bus.ld_count);
                end
            end
        end
        total++; if (bus.ld_count !== 7'd64) begin bad++; $display("FAIL full_count got=%0d want=64", bus.ld_count); end
        total++; if (bus.cpu_rst !== 1'b0) begin bad++; $display("FAIL full_cpu_rst got=%b want=0", bus.cpu_rst); end
        bus.ld_valid = 1'b1;
        step;
        step;
        bus.ld_valid = 1'b0;
        total++; if (bus.ld_count !== 7'd64 || bus.ld_ready !== 1'b0) begin
            bad++; $display("FAIL full_hold got count=%0d ready=%b want 64/0", bus.ld_count, bus.ld_ready);
        end
        rd(6'd33);
        total++; if (bus.mdr_out !== 10'h0EA) begin bad++; $display("FAIL full_rd33 got=%h want=0ea", bus.mdr_out); end
        rd(6'd63);
`ifdef FBCPU_MEM_IO_EN
        total++; if (bus.mdr_out !== 10'h000) begin bad++; $display("FAIL full_rd63 got=%h want=000", bus.mdr_out); end
`else
        total++; if (bus.mdr_out !== 10'h1BC) begin bad++; $display("FAIL full_rd63 got=%h want=1bc", bus.mdr_out); end
`endif
    endtask

    task automatic test_io;
        bus.mar = 6'd63; bus.ram_wr = 1'b1; bus.mdr_in = 10'h155;
        step;
        bus.ram_wr = 1'b0;
`ifdef FBCPU_MEM_IO_EN
        total++; if (bus.io_out !== 10'h155) begin bad++; $display("FAIL io_out got=%h want=155", bus.io_out); end
`else
        total++; if (bus.io_out !== 10'h000) begin bad++; $display("FAIL io_out got=%h want=000", bus.io_out); end
`endif
        rd(6'd63);
        total++; if (bus.mdr_out !== 10'h155) begin bad++; $display("FAIL io_rd63 got=%h want=155", bus.mdr_out); end
        bus.mar = 6'd62; bus.ram_wr = 1'b1; bus.mdr_in = 10'h0F0;
        step;
        rd(6'd62);
        total++; if (bus.mdr_out !== 10'h0F0) begin bad++; $display("FAIL io_rd62 got=%h want=0f0", bus.mdr_out); end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] exp_w [5] = '{10'h311, 10'h312, 10'h313, 10'h314, 10'h315};
        do_reset;
        load_word(10'h301, 1'b0);
        load_word(10'h302, 1'b0);
        total++; if (bus.ld_count !== 7'd2) begin bad++; $display("FAIL mid_count2 got=%0d want=2", bus.ld_count); end
        do_reset;
        total++; if (bus.ld_count !== 7'd0 || bus.cpu_rst !== 1'b1) begin
            bad++; $display("FAIL mid_reset got count=%0d cpu_rst=%b want 0/1", bus.ld_count, bus.cpu_rst);
        end
        for (int i = 0; i < 5; i++) load_word(exp_w[i], i == 4);
        total++; if (bus.ld_count !== 7'd5 || bus.cpu_rst !== 1'b0) begin
            bad++; $display("FAIL mid_reload got count=%0d cpu_rst=%b want 5/0", bus.ld_count, bus.cpu_rst);
        end
        for (int i = 0; i < 5; i++) begin
            rd(6'(i));
            total++; if (bus.mdr_out !== exp_w[i]) begin
                bad++; $display("FAIL mid_rd%0d got=%h want=%h", i, bus.mdr_out, exp_w[i]);
            end
        end
        rd(6'd5);
        total++; if (bus.mdr_out !== 10'h026) begin bad++; $display("FAIL mid_keep5 got=%h want=026", bus.mdr_out); end
    endtask

    task automatic test_rst_priority;
        bus.mar = 6'd20; bus.ram_wr = 1'b1; bus.mdr_in = 10'h2DD;
        do_reset;
        bus.ram_wr = 1'b0;
        total++; if (bus.cpu_rst !== 1'b1 || bus.ld_count !== 7'd0) begin
            bad++; $display("FAIL prio_state got cpu_rst=%b count=%0d want 1/0", bus.cpu_rst, bus.ld_count);
        end
        load_word(10'h0AB, 1'b1);
        rd(6'd20);
        total++; if (bus.mdr_out !== 10'h08F) begin bad++; $display("FAIL prio_rd20 got=%h want=08f", bus.mdr_out); end
        rd(6'd0);
        total++; if (bus.mdr_out !== 10'h0AB) begin bad++; $display("FAIL prio_rd0 got=%h want=0ab", bus.mdr_out); end
    endtask

    task automatic test_gaps;
        logic          vld_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [DW-1:0] dat_pat [7] = '{10'h101, 10'h3FF, 10'h3FE, 10'h102, 10'h3FD, 10'h103, 10'h104};
        int            cnt_pat [7] = '{1, 1, 1, 2, 2, 3, 4};
        logic [DW-1:0] exp_w   [4] = '{10'h101, 10'h102, 10'h103, 10'h104};
        do_reset;
        for (int i = 0; i < 7; i++) begin
            bus.ld_valid = vld_pat[i];
            bus.ld_data  = dat_pat[i];
            bus.ld_last  = (i == 6);
            step;
            total++; if (bus.ld_count !== 7'(cnt_pat[i])) begin
                bad++; $display("FAIL gap_count%0d got=%0d want=%0d", i, bus.ld_count, cnt_pat[i]);
            end
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        total++; if (bus.cpu_rst !== 1'b0) begin bad++; $display("FAIL gap_cpu_rst got=%b want=0", bus.cpu_rst); end
        for (int i = 0; i < 4; i++) begin
            rd(6'(i));
            total++; if (bus.mdr_out !== exp_w[i]) begin
                bad++; $display("FAIL gap_rd%0d got=%h want=%h", i, bus.mdr_out, exp_w[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mar = '0; bus.ram_wr = 1'b0; bus.mdr_in = '0;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
        test_reset;
        test_basic_load;
        test_cpu_rw;
        test_full;
        test_io;
        test_reset_mid;
        test_rst_priority;
        test_gaps;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fbcpu_mem_loader.md
FBCPU_MEM_LOADER -- requirements
Module: fbcpu_mem_loader

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 6, width of the CPU/loader word address.
REQ-002 Parameter DATA_WIDTH, default 10, width of a memory word and of the instruction word.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high; clock clk.
REQ-005 mar  input  ADDRESS_WIDTH  CPU address (driven from CPU MAR).
REQ-006 ram_wr  input  1  CPU write strobe (driven from CPU RAMWr).
REQ-007 mdr_in  input  DATA_WIDTH  CPU write data (driven from CPU MDRIn).
REQ-008 mdr_out  output  DATA_WIDTH  registered read data to CPU MDROut.
REQ-009 cpu_rst  output  1  reset to the CPU core, high while the program is being loaded.
REQ-010 ld_valid  input  1  loader word valid.
REQ-011 ld_data  input  DATA_WIDTH  loader word.
REQ-012 ld_last  input  1  qualifies ld_valid; marks the final program word.
REQ-013 ld_ready  output  1  loader may transfer; a word transfers on a cycle with ld_valid and ld_ready both high.
REQ-014 ld_count  output  ADDRESS_WIDTH+1  number of words accepted in the current load.
REQ-015 io_out  output  DATA_WIDTH  memory-mapped output port (see Configuration).

Function
REQ-016 Storage: 2**ADDRESS_WIDTH words of DATA_WIDTH bits; no reset clear of contents.
REQ-017 States: LOAD, RUN; LOAD entered on reset.
REQ-018 LOAD: cpu_rst=1, ld_ready=1; each transfer writes ld_data to address ld_count[ADDRESS_WIDTH-1:0], then increments ld_count.
REQ-019 LOAD->RUN on the clock edge of a transfer with ld_last=1, or of the transfer to address 2**ADDRESS_WIDTH-1 (full; ld_last ignored); ld_count then holds the total accepted words.
REQ-020 RUN: cpu_rst=0 from the first cycle in RUN; ld_ready=0; ld_valid ignored; ld_count held.
REQ-021 RUN read: mdr_out <= mem[mar] at every rising edge; one-cycle latency, matching CPU fetch (MAR in one cycle, MDROut sampled in the next).
REQ-022 RUN write: ram_wr=1 writes mdr_in to mem[mar] at the edge; mdr_out that edge shows the old word (read-before-write).
REQ-023 LOAD: ram_wr and mar ignored for writes; mdr_out <= 0 each cycle.
REQ-024 ld_valid with ld_ready low: no transfer, no state change.
REQ-025 RUN is terminal until rst; no return to LOAD otherwise.

Reset
REQ-026 rst high at an edge: state=LOAD, ld_count=0, mdr_out=0, io_out=0; cpu_rst=1 and ld_ready=1 combinationally while in LOAD.
REQ-027 rst has priority over any transfer or CPU write on the same edge; that word is not written.
REQ-028 rst mid-load: count restarts at 0; already-written words remain until overwritten.

Configuration
REQ-029 Macro FBCPU_MEM_IO_EN defined: in RUN, CPU write to address 2**ADDRESS_WIDTH-1 updates io_out instead of memory, and a read of that address returns io_out.
REQ-030 FBCPU_MEM_IO_EN undefined: io_out tied to 0; address 2**ADDRESS_WIDTH-1 is ordinary memory.

Verification
REQ-031 rst 1 cycle, then load 3 words 0x005,0x0C5,0x200 with ld_last on third -> ld_count=3, cpu_rst falls the edge after the third transfer, mem[0..2] match.
REQ-032 After load, mar=1 in cycle n -> mdr_out=0x0C5 in cycle n+1; ram_wr=1, mar=10, mdr_in=0x3FF -> next read of 10 returns 0x3FF, same-edge mdr_out shows old value.
REQ-033 Load 64 words without ld_last -> RUN after 64th transfer, ld_count=64; further ld_valid ignored, ld_ready=0.
REQ-034 rst asserted after 2 of 5 words -> ld_count=0, cpu_rst=1; reload 5 words -> addresses 0..4 contain new words.
REQ-035 With FBCPU_MEM_IO_EN: CPU write 0x155 to address 63 -> io_out=0x155, mem[63] unchanged; without: io_out=0, mem[63]=0x155.
REQ-036 ld_valid held with gaps (valid low cycles) -> only valid cycles counted, addresses contiguous.
